fetch_unit: RTL and testbench

Instruction-fetch stage controller that produces the instruction stream for the IF/ID pipeline register. It owns the PC and issues one-at-a-time reads to a multi-cycle instruction memory that answers with a done/stall handshake. It holds one fetched instruction in a buffer while the pipeline stalls, and redirects on resolved branches and jumps. Downstream bubbles are NOP (16'h0800) with the error flag carried alongside.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buf.sv | 58 +++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int PC_W = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(2);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry fetch buffer: instruction, its PC+2 and error flag, plus valid.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [15:0]     instr_in,
    input  logic [PC_W-1:0] pc2_in,
    input  logic            err_in,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] pc2,
    output logic            err,
    output logic            valid
);

    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc2_q, pc2_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;

    // A load wins over a clear so a consume and a refill can share one edge.
    always_comb begin
        instr_d = instr_q;
        pc2_d   = pc2_q;
        err_d   = err_q;
        valid_d = valid_q;
        if (load) begin
            instr_d = instr_in;
            pc2_d   = pc2_in;
            err_d   = err_in;
            valid_d = 1'b1;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc2_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc2   = pc2_q;
    assign err   = err_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, issues single reads to a
// multi-cycle instruction memory and feeds IF/ID through a one-entry buffer.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_FETCH  | idle at pc; issue a read once the buffer has room
//   ST_WAIT   | read outstanding; wait for mem_done (sq: discard result)
//   ST_HALTED | no more reads until reset; buffer still drains
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_err,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus_two_out,
    output logic        err_out,
    output logic        fetch_busy
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            sq_q, sq_d;
    logic            halt_pend_q, halt_pend_d;

    logic            buf_load, buf_clear;
    logic [15:0]     ld_instr;
    logic [PC_W-1:0] ld_pc2;
    logic            ld_err;
    logic [15:0]     buf_instr;
    logic [PC_W-1:0] buf_pc2;
    logic            buf_err, buf_v;
    logic            consume, slot, issue;

    fetch_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (ld_instr),
        .pc2_in   (ld_pc2),
        .err_in   (ld_err),
        .instr    (buf_instr),
        .pc2      (buf_pc2),
        .err      (buf_err),
        .valid    (buf_v)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sq_d        = sq_q;
        halt_pend_d = halt_pend_q;
        issue       = 1'b0;
        buf_load    = 1'b0;
        ld_instr    = mem_data;
        ld_pc2      = pc_next(pc_q);
        ld_err      = 1'b0;
        consume     = buf_v & ~stall_in;
        slot        = ~buf_v | consume;
        buf_clear   = consume | redirect;

        if (redirect) begin
            // The redirect comes from an older instruction, so any pending halt is wrong-path.
            pc_d        = redirect_pc;
            halt_pend_d = 1'b0;
            if (state_q == ST_WAIT) begin
                if (mem_done) begin
                    sq_d    = 1'b0;
                    state_d = ST_FETCH;
                end else begin
                    sq_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (slot) begin
                        if (pc_q[0]) begin
                            buf_load = 1'b1;
                            ld_instr = NOP;
                            ld_err   = 1'b1;
                            state_d  = ST_HALTED;
                        end else if (!mem_stall) begin
                            issue   = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        if (sq_q || halt) begin
                            sq_d        = 1'b0;
                            halt_pend_d = 1'b0;
                            state_d     = (halt_pend_q || halt) ? ST_HALTED : ST_FETCH;
                        end else begin
                            buf_load = 1'b1;
                            ld_instr = mem_err ? NOP : mem_data;
                            ld_err   = mem_err;
                            pc_d     = pc_next(pc_q);
                            state_d  = mem_err ? ST_HALTED : ST_FETCH;
                        end
                    end else if (halt) begin
                        sq_d        = 1'b1;
                        halt_pend_d = 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            sq_q        <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sq_q        <= sq_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Reset gates the request so no read escapes while rst is asserted.
    assign mem_rd          = issue & ~rst;
    assign mem_addr        = pc_q;
    assign instr_out       = buf_v ? buf_instr : NOP;
    assign pc_plus_two_out = buf_pc2;
    assign err_out         = buf_v & buf_err;
    assign fetch_busy      = ~buf_v;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: one table row per clock cycle.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = '0;
    logic        mem_done = 1'b0;
    logic        mem_stall = 1'b0;
    logic        mem_err = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] pc_plus_two_out;
    logic        err_out;
    logic        fetch_busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .mem_addr        (mem_addr),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .mem_done        (mem_done),
        .mem_stall       (mem_stall),
        .mem_err         (mem_err),
        .instr_out       (instr_out),
        .pc_plus_two_out (pc_plus_two_out),
        .err_out         (err_out),
        .fetch_busy      (fetch_busy)
    );

    typedef struct {
        logic        st;
        logic        rd;
        logic [15:0] rpc;
        logic        hl;
        logic        md;
        logic [15:0] mdat;
        logic        ms;
        logic        me;
        logic        e_rd;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic st, input logic rd, input logic [15:0] rpc, input logic hl,
        input logic md, input logic [15:0] mdat, input logic ms, input logic me,
        input logic e_rd, input logic [15:0] e_addr, input logic [15:0] e_instr,
        input logic [15:0] e_pc2, input logic e_err, input logic e_busy);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.hl = hl;
        v.md = md; v.mdat = mdat; v.ms = ms; v.me = me;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_pc2 = e_pc2; v.e_err = e_err; v.e_busy = e_busy;
        return v;
    endfunction

    // Drive one row at a falling edge, check mid-cycle, advance to the next falling edge.
    task automatic apply(input vec_t v, input string nm);
        stall_in = v.st; redirect = v.rd; redirect_pc = v.rpc; halt = v.hl;
        mem_done = v.md; mem_data = v.mdat; mem_stall = v.ms; mem_err = v.me;
        #1;
        n_vec++;
        if (mem_rd !== v.e_rd) begin
            n_bad++; $display("FAIL %s mem_rd act=%b exp=%b", nm, mem_rd, v.e_rd);
        end
        if (mem_addr !== v.e_addr) begin
            n_bad++; $display("FAIL %s mem_addr act=%h exp=%h", nm, mem_addr, v.e_addr);
        end
        if (instr_out !== v.e_instr) begin
            n_bad++; $display("FAIL %s instr_out act=%h exp=%h", nm, instr_out, v.e_instr);
        end
        if (pc_plus_two_out !== v.e_pc2) begin
            n_bad++; $display("FAIL %s pc_plus_two_out act=%h exp=%h", nm, pc_plus_two_out, v.e_pc2);
        end
        if (err_out !== v.e_err) begin
            n_bad++; $display("FAIL %s err_out act=%b exp=%b", nm, err_out, v.e_err);
        end
        if (fetch_busy !== v.e_busy) begin
            n_bad++; $display("FAIL %s fetch_busy act=%b exp=%b", nm, fetch_busy, v.e_busy);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        apply(mk(0,0,16'h0,0, 0,16'h0,0,0, 0,16'h0000,16'h0800,16'h0000,0,1), nm);
        rst = 1'b0;
    endtask

    task automatic idle(input logic e_rd, input logic [15:0] e_addr, input logic [15:0] e_instr,
                        input logic [15:0] e_pc2, input logic e_err, input logic e_busy, input string nm);
        apply(mk(0,0,16'h0,0, 0,16'h0,0,0, e_rd,e_addr,e_instr,e_pc2,e_err,e_busy), nm);
    endtask

    vec_t tbl[$];

    initial begin
        //               st rd rpc     hl md mdat    ms me  rd addr     instr    pc2      er bz
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  1, 16'h0000,16'h0800,16'h0000,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 1, 16'h1234,0, 0,  0, 16'h0000,16'h0800,16'h0000,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  1, 16'h0002,16'h1234,16'h0002,0, 0));
        tbl.push_back(mk(0, 0, 16'h0000,0, 1, 16'h5678,0, 0,  0, 16'h0002,16'h0800,16'h0002,0, 1));
        tbl.push_back(mk(1, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0004,16'h5678,16'h0004,0, 0));
        tbl.push_back(mk(1, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0004,16'h5678,16'h0004,0, 0));
        tbl.push_back(mk(1, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0004,16'h5678,16'h0004,0, 0));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  1, 16'h0004,16'h5678,16'h0004,0, 0));
        tbl.push_back(mk(0, 1, 16'h0040,0, 0, 16'h0000,0, 0,  0, 16'h0004,16'h0800,16'h0004,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0040,16'h0800,16'h0004,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 1, 16'hBEEF,0, 0,  0, 16'h0040,16'h0800,16'h0004,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  1, 16'h0040,16'h0800,16'h0004,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 1, 16'h1111,0, 0,  0, 16'h0040,16'h0800,16'h0004,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,1, 0,  0, 16'h0042,16'h1111,16'h0042,0, 0));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,1, 0,  0, 16'h0042,16'h0800,16'h0042,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,1, 0,  0, 16'h0042,16'h0800,16'h0042,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,1, 0,  0, 16'h0042,16'h0800,16'h0042,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  1, 16'h0042,16'h0800,16'h0042,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 1, 16'h3333,0, 0,  0, 16'h0042,16'h0800,16'h0042,0, 1));
        tbl.push_back(mk(0, 1, 16'h0080,1, 0, 16'h0000,0, 0,  0, 16'h0044,16'h3333,16'h0044,0, 0));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  1, 16'h0080,16'h0800,16'h0044,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 1, 16'h4444,0, 0,  0, 16'h0080,16'h0800,16'h0044,0, 1));
        tbl.push_back(mk(1, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0082,16'h4444,16'h0082,0, 0));
        tbl.push_back(mk(1, 0, 16'h0000,1, 0, 16'h0000,0, 0,  0, 16'h0082,16'h4444,16'h0082,0, 0));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0082,16'h4444,16'h0082,0, 0));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0082,16'h0800,16'h0082,0, 1));
        tbl.push_back(mk(0, 0, 16'h0000,0, 0, 16'h0000,0, 0,  0, 16'h0082,16'h0800,16'h0082,0, 1));

        @(negedge clk);
        do_reset("reset");
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("main[%0d]", i));
        end

        // Reset lands mid-WAIT; the stale mem_done afterwards must be ignored.
        do_reset("rstA");
        idle(1, 16'h0000, 16'h0800, 16'h0000, 0, 1, "rstA_req");
        rst = 1'b1;
        apply(mk(0,0,16'h0,0, 0,16'h0,0,0, 0,16'h0000,16'h0800,16'h0000,0,1), "rstA_midwait");
        rst = 1'b0;
        apply(mk(0,0,16'h0,0, 1,16'h9999,0,0, 1,16'h0000,16'h0800,16'h0000,0,1), "rstA_stale");
        apply(mk(0,0,16'h0,0, 1,16'hAAAA,0,0, 0,16'h0000,16'h0800,16'h0000,0,1), "rstA_done");
        idle(1, 16'h0002, 16'hAAAA, 16'h0002, 0, 0, "rstA_out");

        // Redirect to an odd PC: error bubble, then permanently halted.
        do_reset("rstB");
        apply(mk(0,1,16'h0011,0, 0,16'h0,0,0, 0,16'h0000,16'h0800,16'h0000,0,1), "odd_redir");
        idle(0, 16'h0011, 16'h0800, 16'h0000, 0, 1, "odd_noreq");
        apply(mk(1,0,16'h0,0, 0,16'h0,0,0, 0,16'h0011,16'h0800,16'h0013,1,0), "odd_err_hold");
        idle(0, 16'h0011, 16'h0800, 16'h0013, 1, 0, "odd_err");
        idle(0, 16'h0011, 16'h0800, 16'h0013, 0, 1, "odd_halt1");
        idle(0, 16'h0011, 16'h0800, 16'h0013, 0, 1, "odd_halt2");

        // Halt while a read is outstanding: its data is dropped, then no requests.
        do_reset("rstC");
        idle(1, 16'h0000, 16'h0800, 16'h0000, 0, 1, "hw_req");
        apply(mk(0,0,16'h0,1, 0,16'h0,0,0, 0,16'h0000,16'h0800,16'h0000,0,1), "hw_halt");
        apply(mk(0,0,16'h0,0, 1,16'h5555,0,0, 0,16'h0000,16'h0800,16'h0000,0,1), "hw_done");
        idle(0, 16'h0000, 16'h0800, 16'h0000, 0, 1, "hw_idle1");
        idle(0, 16'h0000, 16'h0800, 16'h0000, 0, 1, "hw_idle2");

        // Memory error: NOP with err flag, PC advanced, then halted.
        do_reset("rstD");
        idle(1, 16'h0000, 16'h0800, 16'h0000, 0, 1, "me_req");
        apply(mk(0,0,16'h0,0, 1,16'h7777,0,1, 0,16'h0000,16'h0800,16'h0000,0,1), "me_done");
        idle(0, 16'h0002, 16'h0800, 16'h0002, 1, 0, "me_out");
        idle(0, 16'h0002, 16'h0800, 16'h0002, 0, 1, "me_halt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
